axi_slave_bram: RTL and testbench

//  AXI4 slave endpoint backed by an on-chip word RAM; the downstream consumer of the AXI master/interconnect traffic.

---
 rtl/axi_slave_bram.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_axi_slave_bram.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_bram.sv
// AXI4 slave endpoint over a 2**DEPTH_LOG2 x 32-bit word RAM; independent single-burst write and read engines.
// Latency: a write beat lands in RAM on its handshake edge; the first read beat is valid 2 cycles after the AR handshake.
// Backpressure: one burst per channel; read beats drain through a 2-entry skid buffer, so RD_DATA_READY low never drops or repeats a beat.
// Ports: clk, rstn (async active-low); WR_ADDR_*/WR_DATA*/WR_STRB/WR_BACK_* write channels; RD_ADDR_*/RD_BACK_ID/RD_DATA* read channels.
module axi_slave_bram #(
    parameter int          ID_WIDTH   = 2,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ID_WIDTH-1:0] WR_ADDR_ID,
    input  logic [31:0]         WR_ADDR,
    input  logic [7:0]          WR_ADDR_LEN,
    input  logic [1:0]          WR_ADDR_BURST,
    input  logic                WR_ADDR_VALID,
    output logic                WR_ADDR_READY,
    input  logic [31:0]         WR_DATA,
    input  logic [3:0]          WR_STRB,
    input  logic                WR_DATA_LAST,
    input  logic                WR_DATA_VALID,
    output logic                WR_DATA_READY,
    output logic [ID_WIDTH-1:0] WR_BACK_ID,
    output logic [1:0]          WR_BACK_RESP,
    output logic                WR_BACK_VALID,
    input  logic                WR_BACK_READY,
    input  logic [ID_WIDTH-1:0] RD_ADDR_ID,
    input  logic [31:0]         RD_ADDR,
    input  logic [7:0]          RD_ADDR_LEN,
    input  logic [1:0]          RD_ADDR_BURST,
    input  logic                RD_ADDR_VALID,
    output logic                RD_ADDR_READY,
    output logic [ID_WIDTH-1:0] RD_BACK_ID,
    output logic [31:0]         RD_DATA,
    output logic [1:0]          RD_DATA_RESP,
    output logic                RD_DATA_LAST,
    output logic                RD_DATA_VALID,
    input  logic                RD_DATA_READY
);
    localparam int            PW      = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    // Top pointer bit set = out of range; the pointer saturates there instead of wrapping.
    localparam logic [PW-1:0] PTR_OOR = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_BURST}        r_state_e;

    function automatic logic [PW-1:0] to_ptr(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        if ((addr < BASE_ADDR) || (|off[31:DEPTH_LOG2+2])) return PTR_OOR;
        return {1'b0, off[DEPTH_LOG2+1:2]};
    endfunction

    // ---------------- RAM (not reset; read-before-write on a shared word) ----------------
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [31:0]           ram_rdat;
    logic                  mem_we, ram_re;
    logic [DEPTH_LOG2-1:0] mem_waddr, ram_raddr;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (WR_STRB[i]) mem[mem_waddr][8*i +: 8] <= WR_DATA[8*i +: 8];
        end
        if (ram_re) ram_rdat <= mem[ram_raddr];
    end

    // ---------------- write engine ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  aw_rdy_q, aw_rdy_d, w_rdy_q, w_rdy_d, b_vld_q, b_vld_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [PW-1:0]         w_ptr_q, w_ptr_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]            w_burst_q, w_burst_d, w_resp_q, w_resp_d;
    logic                  w_over_q, w_over_d, w_err_q, w_err_d;
    logic                  w_beat_ok, w_err_nxt;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_ptr_d   = w_ptr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_over_d  = w_over_q;
        w_err_d   = w_err_q;
        w_resp_d  = w_resp_q;
        w_beat_ok = 1'b0;
        w_err_nxt = w_err_q;
        mem_we    = 1'b0;
        mem_waddr = w_ptr_q[DEPTH_LOG2-1:0];
        unique case (w_state_q)
            W_IDLE: if (WR_ADDR_VALID && aw_rdy_q) begin
                w_id_d    = WR_ADDR_ID;
                w_ptr_d   = to_ptr(WR_ADDR);
                w_len_d   = WR_ADDR_LEN;
                w_burst_d = WR_ADDR_BURST;
                w_cnt_d   = 8'd0;
                w_over_d  = 1'b0;
                w_err_d   = WR_ADDR_BURST[1];   // 10/11 unsupported: whole burst dropped
                w_state_d = W_DATA;
            end
            W_DATA: if (WR_DATA_VALID && w_rdy_q) begin
                w_beat_ok = !w_ptr_q[DEPTH_LOG2] && !w_over_q && !w_burst_q[1];
                mem_we    = w_beat_ok;
                w_err_nxt = w_err_q || !w_beat_ok ||
                            (WR_DATA_LAST && (w_over_q || (w_cnt_q != w_len_q)));
                w_err_d   = w_err_nxt;
                // Any beat after beat LEN is surplus; the flag survives counter wrap at LEN 255.
                if (w_cnt_q == w_len_q) w_over_d = 1'b1;
                w_cnt_d = w_cnt_q + 8'd1;
                if ((w_burst_q == 2'b01) && !w_ptr_q[DEPTH_LOG2]) w_ptr_d = w_ptr_q + PTR_ONE;
                if (WR_DATA_LAST) begin
                    w_resp_d  = {w_err_nxt, 1'b0};
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (b_vld_q && WR_BACK_READY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        aw_rdy_d = (w_state_d == W_IDLE);
        w_rdy_d  = (w_state_d == W_DATA);
        b_vld_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            aw_rdy_q  <= 1'b0;
            w_rdy_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            w_id_q    <= '0;
            w_ptr_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_over_q  <= 1'b0;
            w_err_q   <= 1'b0;
            w_resp_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_rdy_q  <= aw_rdy_d;
            w_rdy_q   <= w_rdy_d;
            b_vld_q   <= b_vld_d;
            w_id_q    <= w_id_d;
            w_ptr_q   <= w_ptr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_over_q  <= w_over_d;
            w_err_q   <= w_err_d;
            w_resp_q  <= w_resp_d;
        end
    end

    assign WR_ADDR_READY = aw_rdy_q;
    assign WR_DATA_READY = w_rdy_q;
    assign WR_BACK_VALID = b_vld_q;
    assign WR_BACK_ID    = w_id_q;
    assign WR_BACK_RESP  = w_resp_q;

    // ---------------- read engine: fetch -> RAM register (pipe) -> 2-entry skid ----------------
    r_state_e              r_state_q, r_state_d;
    logic                  ar_rdy_q, ar_rdy_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [PW-1:0]         r_ptr_q, r_ptr_d;
    logic [7:0]            r_len_q, r_len_d, f_cnt_q, f_cnt_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic                  f_done_q, f_done_d;
    logic                  p_vld_q, p_vld_d, p_err_q, p_err_d, p_last_q, p_last_d;
    logic [1:0]            s_cnt_q, s_cnt_d;
    logic [31:0]           hd_dat_q, hd_dat_d, tl_dat_q, tl_dat_d, p_dat;
    logic [1:0]            hd_resp_q, hd_resp_d, tl_resp_q, tl_resp_d, p_resp;
    logic                  hd_last_q, hd_last_d, tl_last_q, tl_last_d;
    logic                  r_vld_q, r_vld_d;
    logic                  r_pop, fetch;
    logic [2:0]            r_occ;

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_ptr_d   = r_ptr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        f_cnt_d   = f_cnt_q;
        f_done_d  = f_done_q;
        p_err_d   = p_err_q;
        p_last_d  = p_last_q;
        s_cnt_d   = s_cnt_q;
        hd_dat_d  = hd_dat_q;
        hd_resp_d = hd_resp_q;
        hd_last_d = hd_last_q;
        tl_dat_d  = tl_dat_q;
        tl_resp_d = tl_resp_q;
        tl_last_d = tl_last_q;
        ram_raddr = r_ptr_q[DEPTH_LOG2-1:0];
        r_pop     = r_vld_q && RD_DATA_READY;
        // Fetch only when the beat can never overflow the skid: entries held + in flight - leaving now < 2.
        r_occ     = {1'b0, s_cnt_q} + {2'b00, p_vld_q} - {2'b00, r_pop};
        fetch     = (r_state_q == R_BURST) && !f_done_q && (r_occ < 3'd2);
        ram_re    = fetch;
        p_vld_d   = fetch;
        p_dat     = p_err_q ? 32'h0 : ram_rdat;
        p_resp    = {p_err_q, 1'b0};

        unique case (r_state_q)
            R_IDLE: if (RD_ADDR_VALID && ar_rdy_q) begin
                r_id_d    = RD_ADDR_ID;
                r_ptr_d   = to_ptr(RD_ADDR);
                r_len_d   = RD_ADDR_LEN;
                r_burst_d = RD_ADDR_BURST;
                f_cnt_d   = 8'd0;
                f_done_d  = 1'b0;
                r_state_d = R_BURST;
            end
            R_BURST: if (r_pop && hd_last_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase

        if (fetch) begin
            p_err_d  = r_ptr_q[DEPTH_LOG2] || r_burst_q[1];
            p_last_d = (f_cnt_q == r_len_q);
            if (f_cnt_q == r_len_q) f_done_d = 1'b1;
            else                    f_cnt_d  = f_cnt_q + 8'd1;
            if ((r_burst_q == 2'b01) && !r_ptr_q[DEPTH_LOG2]) r_ptr_d = r_ptr_q + PTR_ONE;
        end

        // Skid buffer: head drives the port; tail only fills while the head is stalled.
        unique case (s_cnt_q)
            2'd0: if (p_vld_q) begin
                hd_dat_d = p_dat; hd_resp_d = p_resp; hd_last_d = p_last_q; s_cnt_d = 2'd1;
            end
            2'd1: begin
                if (r_pop && p_vld_q) begin
                    hd_dat_d = p_dat; hd_resp_d = p_resp; hd_last_d = p_last_q;
                end else if (r_pop) begin
                    s_cnt_d = 2'd0;
                end else if (p_vld_q) begin
                    tl_dat_d = p_dat; tl_resp_d = p_resp; tl_last_d = p_last_q; s_cnt_d = 2'd2;
                end
            end
            default: if (r_pop) begin
                hd_dat_d = tl_dat_q; hd_resp_d = tl_resp_q; hd_last_d = tl_last_q;
                if (p_vld_q) begin
                    tl_dat_d = p_dat; tl_resp_d = p_resp; tl_last_d = p_last_q;
                end else begin
                    s_cnt_d = 2'd1;
                end
            end
        endcase
        r_vld_d  = (s_cnt_d != 2'd0);
        ar_rdy_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            ar_rdy_q  <= 1'b0;
            r_id_q    <= '0;
            r_ptr_q   <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            f_cnt_q   <= '0;
            f_done_q  <= 1'b0;
            p_vld_q   <= 1'b0;
            p_err_q   <= 1'b0;
            p_last_q  <= 1'b0;
            s_cnt_q   <= '0;
            hd_dat_q  <= '0;
            hd_resp_q <= '0;
            hd_last_q <= 1'b0;
            tl_dat_q  <= '0;
            tl_resp_q <= '0;
            tl_last_q <= 1'b0;
            r_vld_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            ar_rdy_q  <= ar_rdy_d;
            r_id_q    <= r_id_d;
            r_ptr_q   <= r_ptr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            f_cnt_q   <= f_cnt_d;
            f_done_q  <= f_done_d;
            p_vld_q   <= p_vld_d;
            p_err_q   <= p_err_d;
            p_last_q  <= p_last_d;
            s_cnt_q   <= s_cnt_d;
            hd_dat_q  <= hd_dat_d;
            hd_resp_q <= hd_resp_d;
            hd_last_q <= hd_last_d;
            tl_dat_q  <= tl_dat_d;
            tl_resp_q <= tl_resp_d;
            tl_last_q <= tl_last_d;
            r_vld_q   <= r_vld_d;
        end
    end

    assign RD_ADDR_READY = ar_rdy_q;
    assign RD_BACK_ID    = r_id_q;
    assign RD_DATA       = hd_dat_q;
    assign RD_DATA_RESP  = hd_resp_q;
    assign RD_DATA_LAST  = hd_last_q;
    assign RD_DATA_VALID = r_vld_q;

endmodule

// File: tb/tb_axi_slave_bram.sv
// Directed bench for axi_slave_bram: write/read bursts, strobes, FIXED, out-of-range, stalls, mid-burst reset.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Read data is collected with RD_DATA_READY either held high or toggled randomly.
module tb_axi_slave_bram;
    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  WR_ADDR_ID, WR_ADDR_BURST, WR_BACK_ID, WR_BACK_RESP;
    logic [31:0] WR_ADDR, WR_DATA;
    logic [7:0]  WR_ADDR_LEN;
    logic [3:0]  WR_STRB;
    logic        WR_ADDR_VALID, WR_ADDR_READY, WR_DATA_LAST, WR_DATA_VALID, WR_DATA_READY;
    logic        WR_BACK_VALID, WR_BACK_READY;
    logic [1:0]  RD_ADDR_ID, RD_ADDR_BURST, RD_BACK_ID, RD_DATA_RESP;
    logic [31:0] RD_ADDR, RD_DATA;
    logic [7:0]  RD_ADDR_LEN;
    logic        RD_ADDR_VALID, RD_ADDR_READY, RD_DATA_LAST, RD_DATA_VALID, RD_DATA_READY;

    always #5 clk = ~clk;

    axi_slave_bram #(.ID_WIDTH(2), .DEPTH_LOG2(12), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rstn(rstn),
        .WR_ADDR_ID(WR_ADDR_ID), .WR_ADDR(WR_ADDR), .WR_ADDR_LEN(WR_ADDR_LEN),
        .WR_ADDR_BURST(WR_ADDR_BURST), .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
        .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_LAST(WR_DATA_LAST),
        .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
        .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP), .WR_BACK_VALID(WR_BACK_VALID),
        .WR_BACK_READY(WR_BACK_READY),
        .RD_ADDR_ID(RD_ADDR_ID), .RD_ADDR(RD_ADDR), .RD_ADDR_LEN(RD_ADDR_LEN),
        .RD_ADDR_BURST(RD_ADDR_BURST), .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
        .RD_BACK_ID(RD_BACK_ID), .RD_DATA(RD_DATA), .RD_DATA_RESP(RD_DATA_RESP),
        .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          tmo = 0;
    logic [31:0] rd_dat  [300];
    logic [1:0]  rd_resp [300];
    int          nb, first_lat, stall_bad, id_bad;
    logic [1:0]  b_id, b_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        WR_ADDR_ID = id; WR_ADDR = addr; WR_ADDR_LEN = len; WR_ADDR_BURST = burst; WR_ADDR_VALID = 1'b1;
        while (!WR_ADDR_READY && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) tmo++;
        @(posedge clk); #1;
        WR_ADDR_VALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] dat, input logic [3:0] strb, input logic last);
        int t = 0;
        WR_DATA = dat; WR_STRB = strb; WR_DATA_LAST = last; WR_DATA_VALID = 1'b1;
        while (!WR_DATA_READY && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) tmo++;
        @(posedge clk); #1;
        WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
    endtask

    task automatic get_b();
        int t = 0;
        WR_BACK_READY = 1'b1;
        while (!WR_BACK_VALID && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) tmo++;
        b_id = WR_BACK_ID; b_resp = WR_BACK_RESP;
        @(posedge clk); #1;
        WR_BACK_READY = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit rnd);
        int          t = 0;
        int          edges = 0;
        bit          done = 0;
        bit          held = 0;
        logic [34:0] hv = '0;
        RD_ADDR_ID = id; RD_ADDR = addr; RD_ADDR_LEN = len; RD_ADDR_BURST = burst;
        RD_ADDR_VALID = 1'b1; RD_DATA_READY = 1'b0;
        while (!RD_ADDR_READY && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) tmo++;
        @(posedge clk); #1;
        RD_ADDR_VALID = 1'b0;
        nb = 0; first_lat = -1; stall_bad = 0; id_bad = 0;
        while (!done && edges < 3000) begin
            RD_DATA_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (RD_DATA_VALID) begin
                if (first_lat < 0) first_lat = edges;
                if (held && (hv !== {RD_DATA, RD_DATA_RESP, RD_DATA_LAST})) stall_bad++;
                if (RD_BACK_ID !== id) id_bad++;
                if (RD_DATA_READY) begin
                    if (nb < 300) begin rd_dat[nb] = RD_DATA; rd_resp[nb] = RD_DATA_RESP; end
                    nb++;
                    held = 0;
                    if (RD_DATA_LAST) done = 1;
                end else begin
                    held = 1;
                    hv = {RD_DATA, RD_DATA_RESP, RD_DATA_LAST};
                end
            end else if (held) begin
                stall_bad++;
            end
            @(posedge clk); #1; edges++;
        end
        RD_DATA_READY = 1'b0;
        if (!done) tmo++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rstn = 1'b1;
        WR_ADDR_ID = '0; WR_ADDR = '0; WR_ADDR_LEN = '0; WR_ADDR_BURST = '0; WR_ADDR_VALID = 1'b0;
        WR_DATA = '0; WR_STRB = '0; WR_DATA_LAST = 1'b0; WR_DATA_VALID = 1'b0; WR_BACK_READY = 1'b0;
        RD_ADDR_ID = '0; RD_ADDR = '0; RD_ADDR_LEN = '0; RD_ADDR_BURST = '0; RD_ADDR_VALID = 1'b0;
        RD_DATA_READY = 1'b0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID, WR_BACK_ID, WR_BACK_RESP,
                              RD_ADDR_READY, RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID}, 0);
        @(negedge clk); rstn = 1'b1;
        #1 chk("aw_ready_before_edge", WR_ADDR_READY, 0);
        @(posedge clk); #1;
        chk("aw_ready_after_release", WR_ADDR_READY, 1);
        chk("ar_ready_after_release", RD_ADDR_READY, 1);

        // 1: INCR write 0..3, read back with latency/LAST/RESP
        do_aw(2'b01, 32'h0, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(32'(i), 4'hF, i == 3);
        get_b();
        chk("t1_b_id", b_id, 2'b01);
        chk("t1_b_resp", b_resp, 2'b00);
        do_read(2'b10, 32'h0, 8'd3, 2'b01, 0);
        chk("t1_first_latency", first_lat, 2);
        chk("t1_beats", nb, 4);
        for (int i = 0; i < 4; i++) chk("t1_data", rd_dat[i], 32'(i));
        chk("t1_resp", {rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, 8'h00);
        chk("t1_rd_id", id_bad, 0);

        // 2: byte strobes
        do_aw(2'b00, 32'h14, 8'd0, 2'b01);
        w_beat(32'h1122_3344, 4'hF, 1'b1);
        get_b();
        do_aw(2'b00, 32'h14, 8'd0, 2'b01);
        w_beat(32'hAABB_CCDD, 4'b0011, 1'b1);
        get_b();
        chk("t2_b_resp", b_resp, 2'b00);
        do_read(2'b00, 32'h14, 8'd0, 2'b01, 0);
        chk("t2_beats", nb, 1);
        chk("t2_data", rd_dat[0], 32'h1122_CCDD);

        // 3: 256-beat burst, random read stalls
        do_aw(2'b11, 32'h0, 8'd255, 2'b01);
        for (int i = 0; i < 256; i++) w_beat(32'(i), 4'hF, i == 255);
        get_b();
        chk("t3_b_id", b_id, 2'b11);
        chk("t3_b_resp", b_resp, 2'b00);
        do_read(2'b11, 32'h0, 8'd255, 2'b01, 1);
        chk("t3_beats", nb, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (rd_dat[i] !== 32'(i) || rd_resp[i] !== 2'b00) bad++;
        chk("t3_data_mismatches", bad, 0);
        chk("t3_stall_unstable", stall_bad, 0);

        // 4: FIXED bursts
        do_aw(2'b01, 32'h10, 8'd3, 2'b00);
        for (int i = 0; i < 4; i++) w_beat(32'(10 + i), 4'hF, i == 3);
        get_b();
        chk("t4_b_resp", b_resp, 2'b00);
        do_read(2'b01, 32'h10, 8'd0, 2'b01, 0);
        chk("t4_word4", rd_dat[0], 32'd13);
        do_read(2'b01, 32'h10, 8'd3, 2'b00, 0);
        chk("t4_fixed_beats", nb, 4);
        for (int i = 0; i < 4; i++) chk("t4_fixed_data", rd_dat[i], 32'd13);

        // 5: burst crossing the top of the RAM
        do_aw(2'b10, 32'h0000_3FF8, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(32'hA0 + 32'(i), 4'hF, i == 3);
        get_b();
        chk("t5_b_id", b_id, 2'b10);
        chk("t5_b_resp", b_resp, 2'b10);
        do_read(2'b10, 32'h0000_3FF8, 8'd3, 2'b01, 0);
        chk("t5_beats", nb, 4);
        chk("t5_data", {rd_dat[0], rd_dat[1], rd_dat[2], rd_dat[3]},
            {32'hA0, 32'hA1, 32'h0, 32'h0});
        chk("t5_resp", {rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, 8'b00_00_10_10);

        // unsupported burst type on read: zeros, SLVERR, LAST on final beat
        do_read(2'b11, 32'h0, 8'd1, 2'b10, 0);
        chk("bad_burst_beats", nb, 2);
        chk("bad_burst_data", {rd_dat[0], rd_dat[1]}, 64'h0);
        chk("bad_burst_resp", {rd_resp[0], rd_resp[1]}, 4'b1010);
        chk("bad_burst_id", id_bad, 0);

        // 6: reset in the middle of an 8-beat write
        do_aw(2'b10, 32'h0, 8'd7, 2'b01);
        w_beat(32'h200, 4'hF, 1'b0);
        w_beat(32'h201, 4'hF, 1'b0);
        WR_DATA = 32'h202; WR_STRB = 4'hF; WR_DATA_VALID = 1'b1;
        #2 rstn = 1'b0;
        #1 chk("t6_async_reset_outputs", {WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID, WR_BACK_ID, WR_BACK_RESP,
                                         RD_ADDR_READY, RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST,
                                         RD_DATA_VALID}, 0);
        WR_DATA_VALID = 1'b0;
        @(negedge clk); rstn = 1'b1;
        #1 chk("t6_aw_ready_before_edge", WR_ADDR_READY, 0);
        @(posedge clk); #1;
        chk("t6_aw_ready_after_release", WR_ADDR_READY, 1);
        chk("t6_no_back_valid", WR_BACK_VALID, 0);
        do_read(2'b00, 32'h0, 8'd2, 2'b01, 0);
        chk("t6_beats", nb, 3);
        chk("t6_words", {rd_dat[0], rd_dat[1], rd_dat[2]}, {32'h200, 32'h201, 32'h2});

        chk("handshake_timeouts", tmo, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
